// File: rtl/insfetch_queue_pkg.sv
// Shared constants and immediate decoders for the instruction-fetch front end.
// RVC constants are only used when INSFETCH_RVC_EN is defined.
package insfetch_queue_pkg;

  localparam logic [6:0] ojal   = 7'b1101111;
  localparam logic [6:0] ojalr  = 7'b1100111;

  localparam logic [1:0] oc_q1  = 2'b01;
  localparam logic [1:0] oc_q2  = 2'b10;
  localparam logic [2:0] fc_j   = 3'b101;
  localparam logic [2:0] fc_jal = 3'b001;
  localparam logic [2:0] fc_jr  = 3'b100;

  typedef enum logic {
    ST_FETCH,
    ST_STUCK
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ins;
    logic        c;
  } q_entry_t;

  // J-type immediate, sign-extended, bit 0 = 0
  function automatic logic [31:0] j_imm(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  // CJ-type immediate of c.j / c.jal, sign-extended, bit 0 = 0
  function automatic logic [31:0] cj_imm(input logic [15:0] w);
    return {{21{w[12]}}, w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
  endfunction

endpackage

// File: rtl/insfetch_queue_predecode.sv
// Combinational predecode: instruction length, jump/stall class and next PC.
// Optional macro: INSFETCH_RVC_EN (16-bit instructions and compressed jumps).
module insfetch_predecode
  import insfetch_queue_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] pc,
  output logic        len2,
  output logic        is_jump,
  output logic        is_stall,
  output logic [31:0] next_pc
);

`ifdef INSFETCH_RVC_EN
  // classify compressed words first, fall back to 32-bit decode
  always_comb begin
    len2     = (word[1:0] != 2'b11);
    is_jump  = 1'b0;
    is_stall = 1'b0;
    next_pc  = pc + 32'd4;
    if (len2) begin
      next_pc = pc + 32'd2;
      if (word[1:0] == oc_q1 && (word[15:13] == fc_j || word[15:13] == fc_jal)) begin
        is_jump = 1'b1;
        next_pc = pc + cj_imm(word[15:0]);
      end else if (word[1:0] == oc_q2 && word[15:13] == fc_jr &&
                   word[11:7] != 5'd0 && word[6:2] == 5'd0) begin
        is_stall = 1'b1;
        next_pc  = pc;
      end
    end else if (word[6:0] == ojal) begin
      is_jump = 1'b1;
      next_pc = pc + j_imm(word);
    end else if (word[6:0] == ojalr) begin
      is_stall = 1'b1;
      next_pc  = pc;
    end
  end
`else
  logic unused_rd_bits;
  assign unused_rd_bits = ^word[11:7];

  // 32-bit only: jal follows, jalr stalls, everything else steps by 4
  always_comb begin
    len2     = 1'b0;
    is_jump  = 1'b0;
    is_stall = 1'b0;
    next_pc  = pc + 32'd4;
    if (word[6:0] == ojal) begin
      is_jump = 1'b1;
      next_pc = pc + j_imm(word);
    end else if (word[6:0] == ojalr) begin
      is_stall = 1'b1;
      next_pc  = pc;
    end
  end
`endif

endmodule

// File: rtl/insfetch_queue.sv
// Instruction fetch front end with a decoupling circular instruction queue.
// Optional macro: INSFETCH_RVC_EN (see insfetch_predecode).
module insfetch_queue
  import insfetch_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RST_PC      = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] out_PC,
  output logic        ask_for,
  input  logic        give_you,
  input  logic [31:0] give_you_ins,
  output logic        is_ins,
  output logic [31:0] ins_addr,
  output logic [31:0] ins,
  output logic        ins_c,
  input  logic        rob_rs_slb_full,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        cancel_stuck
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_state_t     state, state_nx;
  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  q_entry_t         mem [QUEUE_DEPTH];
  q_entry_t         head;

  logic        len2, is_jump, is_stall;
  logic [31:0] next_pc;
  logic        push, pop, normal;

  insfetch_predecode u_predecode (
    .word     (give_you_ins),
    .pc       (pc),
    .len2     (len2),
    .is_jump  (is_jump),
    .is_stall (is_stall),
    .next_pc  (next_pc)
  );

  assign ask_for = (state == ST_FETCH) && (count < CNT_W'(QUEUE_DEPTH));
  assign out_PC  = pc;
  assign is_ins  = (count != '0);
  assign head    = mem[rd_ptr];
  assign ins_addr = is_ins ? head.addr : '0;
  assign ins      = is_ins ? head.ins  : '0;
  assign ins_c    = is_ins & head.c;

  // flush and jalr-resume both take precedence over queue traffic
  assign normal = rdy_in && !rob_clear && !cancel_stuck;
  assign push   = normal && give_you && ask_for;
  assign pop    = normal && is_ins && !rob_rs_slb_full;

  // fetch state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_FETCH;
    else        state <= state_nx;
  end

  // stall on accepted jalr, resume on clear or cancel
  always_comb begin
    state_nx = state;
    if (rdy_in) begin
      if (rob_clear || cancel_stuck) state_nx = ST_FETCH;
      else if (push && is_stall)     state_nx = ST_STUCK;
    end
  end

  // PC, pointers and occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc     <= RST_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        pc     <= rob_new_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (cancel_stuck) begin
        pc <= rob_new_pc;
      end else begin
        if (push) begin
          pc     <= next_pc;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // queue storage; RVC entries are stored zero-extended
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) begin
      mem[wr_ptr] <= '{addr: pc,
                       ins:  len2 ? {16'h0, give_you_ins[15:0]} : give_you_ins,
                       c:    len2};
    end
  end

endmodule

// File: tb/tb_insfetch_queue.sv
// Scoreboard bench for insfetch_queue: driver updates a reference model and
// pushes expected entries; a negedge monitor compares and pops the head.
module tb_insfetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, give_you, rob_rs_slb_full, rob_clear, cancel_stuck;
  logic [31:0] give_you_ins, rob_new_pc;
  logic [31:0] out_PC, ins_addr, ins;
  logic        ask_for, is_ins, ins_c;

  insfetch_queue #(.QUEUE_DEPTH(DEPTH), .RST_PC(RPC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .out_PC(out_PC), .ask_for(ask_for),
    .give_you(give_you), .give_you_ins(give_you_ins),
    .is_ins(is_ins), .ins_addr(ins_addr), .ins(ins), .ins_c(ins_c),
    .rob_rs_slb_full(rob_rs_slb_full), .rob_clear(rob_clear),
    .rob_new_pc(rob_new_pc), .cancel_stuck(cancel_stuck)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  logic        m_stuck;
  bit          mon_en = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: instruction length and next PC from the ISA field rules.
  function automatic bit is_short(input logic [31:0] w);
`ifdef INSFETCH_RVC_EN
    return w[1:0] != 2'b11;
`else
    return 0;
`endif
  endfunction

  function automatic void ref_next(input logic [31:0] w, input logic [31:0] pc,
                                   output logic [31:0] npc, output bit stall);
    int imm;
    stall = 0;
    if (is_short(w)) begin
      npc = pc + 2;
      if (w[1:0] == 2'd1 && (w[15:13] == 3'd5 || w[15:13] == 3'd1)) begin
        imm = (w[12] ? -2048 : 0) + int'(w[11]) * 16 + int'(w[10:9]) * 256 +
              int'(w[8]) * 1024 + int'(w[7]) * 64 + int'(w[6]) * 128 +
              int'(w[5:3]) * 2 + int'(w[2]) * 32;
        npc = pc + imm;
      end else if (w[1:0] == 2'd2 && w[15:13] == 3'd4 && w[11:7] != 0 && w[6:2] == 0) begin
        stall = 1;
        npc   = pc;
      end
    end else if (w[6:0] == 7'h6F) begin
      imm = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 +
            int'(w[30:21]) * 2;
      npc = pc + imm;
    end else if (w[6:0] == 7'h67) begin
      stall = 1;
      npc   = pc;
    end else begin
      npc = pc + 4;
    end
  endfunction

  // Monitor: compare the presented head against the scoreboard, pop on transfer.
  always @(negedge clk_in) begin
    if (mon_en) begin
      chk("is_ins", {31'b0, is_ins}, {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        chk("ins_addr", ins_addr, sb[0].addr);
        chk("ins", ins, sb[0].ins);
        chk("ins_c", {31'b0, ins_c}, {31'b0, sb[0].c});
        if (rdy_in && !rob_rs_slb_full && !rob_clear && !cancel_stuck)
          void'(sb.pop_front());
      end else begin
        chk("ins_addr_empty", ins_addr, 32'h0);
        chk("ins_empty", ins, 32'h0);
      end
    end
  end

  // One cycle: check request outputs, drive inputs, then advance the model.
  task automatic step(input logic gv, input logic [31:0] w, input logic full,
                      input logic clr, input logic cancel, input logic [31:0] npc,
                      input logic rdy);
    bit          exp_ask;
    logic [31:0] nx;
    bit          st;
    exp_ask = !m_stuck && sb.size() < DEPTH;
    chk("ask_for", {31'b0, ask_for}, {31'b0, exp_ask});
    chk("out_PC", out_PC, m_pc);
    give_you = gv; give_you_ins = w; rob_rs_slb_full = full;
    rob_clear = clr; cancel_stuck = cancel; rob_new_pc = npc; rdy_in = rdy;
    @(posedge clk_in);
    if (rdy) begin
      if (clr) begin
        sb.delete(); m_pc = npc; m_stuck = 0;
      end else if (cancel) begin
        m_pc = npc; m_stuck = 0;
      end else if (gv && exp_ask) begin
        ref_next(w, m_pc, nx, st);
        sb.push_back('{addr: m_pc,
                       ins: is_short(w) ? {16'h0, w[15:0]} : w,
                       c: is_short(w)});
        m_pc = nx;
        if (st) m_stuck = 1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1: return 32'h0000_0013;
      2:    return {r[31:7], 7'h6F};
      3:    return {r[31:7], 7'h67};
`ifdef INSFETCH_RVC_EN
      4:    return {r[31:16], 3'b101, r[12:2], 2'b01};
      5:    return {r[31:16], 3'b100, r[12], 5'd1 + 5'(r[10:7]), 5'd0, 2'b10};
      6:    return {r[31:2], 2'b00 | 2'(r[1] & ~r[0])};
`endif
      default: return {r[31:2], 2'b11};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1; rdy_in = 1; give_you = 0; give_you_ins = 0;
    rob_rs_slb_full = 0; rob_clear = 0; cancel_stuck = 0; rob_new_pc = 0;
    m_pc = RPC; m_stuck = 0;
    #12;
    chk("rst_is_ins", {31'b0, is_ins}, 32'h0);
    chk("rst_ins_addr", ins_addr, 32'h0);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_c", {31'b0, ins_c}, 32'h0);
    chk("rst_out_PC", out_PC, RPC);
    rst_in = 0;
    mon_en = 1;
    @(posedge clk_in); #1;

    // fill under back-pressure: four pushes, the fifth is dropped
    for (int unsigned i = 0; i < 5; i++) step(1, 32'h13, 1, 0, 0, 0, 1);
    chk("full_ask_for", {31'b0, ask_for}, 32'h0);
    chk("full_out_PC", out_PC, 32'h10);
    for (int unsigned i = 0; i < 4; i++) step(0, 32'h13, 0, 0, 0, 0, 1);
    // streaming fetch with decoder ready
    for (int unsigned i = 0; i < 4; i++) step(1, 32'h13, 0, 0, 0, 0, 1);
    // jal +0x100 from 0x20
    step(1, 32'h1000_006F, 0, 0, 0, 0, 1);
    chk("jal_out_PC", out_PC, 32'h120);
    // redirect to 0x40, then jalr stalls fetch
    step(1, 32'h13, 0, 1, 0, 32'h40, 1);
    step(1, 32'h0000_80E7, 0, 0, 0, 0, 1);
    chk("jalr_ask_for", {31'b0, ask_for}, 32'h0);
    step(1, 32'h13, 0, 0, 0, 0, 1);
    step(0, 32'h13, 0, 0, 1, 32'h200, 1);
    chk("cancel_ask_for", {31'b0, ask_for}, 32'h1);
    chk("cancel_out_PC", out_PC, 32'h200);
    // three queued entries flushed by a clear with a same-cycle response
    for (int unsigned i = 0; i < 3; i++) step(1, 32'h13, 1, 0, 0, 0, 1);
    step(1, 32'h13, 0, 1, 0, 32'h80, 1);
    chk("clear_is_ins", {31'b0, is_ins}, 32'h0);
    chk("clear_out_PC", out_PC, 32'h80);
`ifdef INSFETCH_RVC_EN
    step(0, 32'h13, 0, 1, 0, 32'h10, 1);
    step(1, 32'h0000_0001, 1, 0, 0, 0, 1);
    chk("cnop_out_PC", out_PC, 32'h12);
    chk("cnop_ins_c", {31'b0, ins_c}, 32'h1);
    step(1, 32'h0000_A021, 0, 0, 0, 0, 1);
    chk("cj_out_PC", out_PC, 32'h1A);
`endif
    // asynchronous reset mid-operation with entries held
    for (int unsigned i = 0; i < 2; i++) step(1, 32'h13, 1, 0, 0, 0, 1);
    mon_en = 0;
    give_you = 0;
    rst_in = 1;
    #1;
    chk("arst_is_ins", {31'b0, is_ins}, 32'h0);
    chk("arst_out_PC", out_PC, RPC);
    chk("arst_ask_for", {31'b0, ask_for}, 32'h1);
    sb.delete(); m_pc = RPC; m_stuck = 0;
    #1 rst_in = 0;
    mon_en = 1;

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      logic clr, cancel;
      clr    = ($urandom_range(0, 99) < 2);
      cancel = m_stuck ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 1);
      step($urandom_range(0, 99) < 70, rand_word(), $urandom_range(0, 99) < 40,
           clr, cancel, $urandom & 32'hFFFF_FFFE, $urandom_range(0, 99) < 90);
    end
    step(0, 32'h13, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
